parity_frame_checker: RTL and testbench
=======================================

# parity_frame_checker

Serial receive-side parity checker, the counterpart of the team's XNOR-chain parity generator. Deserialises an LSB-first frame of DATA_WIDTH data bits followed by one parity bit, compares the received parity against the value the generator produces, and presents the word with its error flag through a one-deep valid/ready output buffer. It also keeps a saturating parity-error count. It sits at the receive end of any serial link whose transmitter appends the XNOR-chain parity.

## Interface
- DATA_WIDTH, 8: data bits per frame, ≥1.
- COUNT_WIDTH, 8: width of the error counter.

- clock  input  1  rising-edge clock, single domain.
- resetN  input  1  asynchronous, active-low reset.
- serialData  input  1  received bit.
- serialValid  input  1  serialData is valid this cycle; low stalls the FSM.
- frameStart  input  1  qualified by serialValid; marks serialData as data bit 0.
- outputData  output  DATA_WIDTH  received word.
- outputParityError  output  1  parity mismatch for outputData.
- outputValid  output  1  outputData/outputParityError valid.
- outputReady  input  1  consumer accepts when outputValid && outputReady.
- overrun  output  1  one-cycle pulse: completed frame dropped.
- errorCount  output  COUNT_WIDTH  saturating count of parity errors.
- counterClear  input  1  synchronous clear of errorCount.

## Operation
- Expected parity equals the generator output: expected = 1 ^ (XOR of data bits) ^ (DATA_WIDTH mod 2).
  - Even DATA_WIDTH: expected = ~XOR(data).
  - Odd DATA_WIDTH: expected = XOR(data).
  - parityError = received parity bit != expected.
- FSM states: IDLE, DATA, PARITY. Bit counter spans 0..DATA_WIDTH-1. Running XOR accumulates as bits shift in.
- Every transition below requires serialValid=1. With serialValid=0, all state, the counter, the shift register and the XOR hold.
- IDLE: frameStart → capture bit 0, set counter=1, XOR=bit.
  - Go to DATA, or to PARITY directly if DATA_WIDTH=1.
  - A valid bit without frameStart is ignored.
- DATA: store the bit at index counter, update XOR, increment counter. After bit DATA_WIDTH-1 is stored → PARITY.
- PARITY: the bit is the parity bit. The frame completes → IDLE.
- frameStart in DATA or PARITY aborts the partial frame. That bit restarts the frame as bit 0 and the state becomes DATA (or PARITY if DATA_WIDTH=1). The aborted frame produces no output and no count.
- Frame completion with the buffer free, or with a handshake in the same cycle: load outputData and outputParityError, set outputValid=1.
- Frame completion with outputValid=1, outputReady=0: the frame is dropped, overrun pulses, and the buffer is unchanged.
- errorCount increments on every completed frame with a parity error, including dropped frames. It saturates at all-ones.
  - counterClear wins over a simultaneous increment (result 0).
- Reset, including mid-frame: state=IDLE, counter=0, outputData=0, outputParityError=0, outputValid=0, overrun=0, errorCount=0. A partial frame is discarded.

## Timing
- All outputs are registered.
- outputValid rises on the clock edge that samples the parity bit. Latency: data visible the cycle after the parity bit.
- Handshake: the buffer clears on the edge where outputValid && outputReady. outputValid then drops the next cycle unless a frame completes on that same edge, in which case it stays 1 with new data.
- outputData and outputParityError stay stable while outputValid=1 and outputReady=0.
- overrun is high for exactly one cycle, the cycle after the dropped parity bit.
- Minimum frame is DATA_WIDTH+1 valid cycles. Back-to-back frames are sustained with frameStart on the cycle right after the parity bit.

## Test plan
- DATA_WIDTH=8, send 0x5A LSB-first with frameStart on bit 0, parity 1, outputReady=1 → outputData=0x5A, outputParityError=0, outputValid high one cycle, errorCount=0.
- Same frame with parity 0 → outputParityError=1, errorCount=1. Repeat 300 times (COUNT_WIDTH=8) → errorCount saturates at 255. Assert counterClear with an erroring frame completing → 0.
- DATA_WIDTH=7, data 0x07, parity 1 → no error; parity 0 → error. Exercises odd-width parity.
- outputReady=0, two back-to-back frames 0x11 then 0x22 → outputData holds 0x11, overrun pulses once. Raise outputReady on the second frame's parity cycle instead → 0x22 loads, outputValid stays 1.
- Random serialValid gaps inside a frame → result identical to the gap-free case. frameStart at bit 4 → first frame discarded, the new frame decodes correctly.
- resetN low mid-frame (bit 3) and with outputValid=1 → all outputs 0 immediately (asynchronous). The next full frame decodes correctly.

Source files
------------

// File: rtl/parity_frame_checker.sv
// Receive-side checker for XNOR-chain parity frames: deserialises LSB-first data plus one
// parity bit, flags mismatches, buffers one word behind valid/ready and counts errors.
module parity_frame_checker #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   serialData,
    input  logic                   serialValid,
    input  logic                   frameStart,
    output logic [DATA_WIDTH-1:0]  outputData,
    output logic                   outputParityError,
    output logic                   outputValid,
    input  logic                   outputReady,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] errorCount,
    input  logic                   counterClear
);

    localparam int unsigned CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntWidth-1:0] LastBit = CntWidth'(DATA_WIDTH - 1);
    localparam logic OddWidth = (DATA_WIDTH % 2) == 1;

    typedef enum logic [1:0] {Idle, Data, Parity} stateE;

    stateE                 state;
    logic [CntWidth-1:0]   bitCount;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic                  runningXor;

    logic expectedParity;
    logic parityBad;
    logic frameDone;
    logic bufferFree;

    // Generator output is 1 ^ XOR(data) ^ (DATA_WIDTH mod 2).
    always_comb begin
        expectedParity = ~(runningXor ^ OddWidth);
        parityBad      = serialData != expectedParity;
        frameDone      = serialValid && !frameStart && (state == Parity);
        bufferFree     = !outputValid || outputReady;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state             <= Idle;
            bitCount          <= '0;
            shiftReg          <= '0;
            runningXor        <= 1'b0;
            outputData        <= '0;
            outputParityError <= 1'b0;
            outputValid       <= 1'b0;
            overrun           <= 1'b0;
            errorCount        <= '0;
        end else begin
            overrun <= 1'b0;
            if (outputValid && outputReady) begin
                outputValid <= 1'b0;
            end

            if (serialValid) begin
                // frameStart restarts from any state, discarding a partial frame.
                if (frameStart) begin
                    shiftReg[0] <= serialData;
                    runningXor  <= serialData;
                    bitCount    <= CntWidth'(1);
                    state       <= (DATA_WIDTH == 1) ? Parity : Data;
                end else begin
                    case (state)
                        Data: begin
                            shiftReg[bitCount] <= serialData;
                            runningXor         <= runningXor ^ serialData;
                            bitCount           <= bitCount + CntWidth'(1);
                            if (bitCount == LastBit) begin
                                state <= Parity;
                            end
                        end
                        Parity: begin
                            state    <= Idle;
                            bitCount <= '0;
                            if (bufferFree) begin
                                outputData        <= shiftReg;
                                outputParityError <= parityBad;
                                outputValid       <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // Dropped frames still count; clear takes priority over an increment.
            if (counterClear) begin
                errorCount <= '0;
            end else if (frameDone && parityBad && (errorCount != '1)) begin
                errorCount <= errorCount + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised bench for parity_frame_checker: a bit-queue frame model predicts the output
// buffer, overrun pulse and error count; a second 7-bit instance covers odd widths.
module tb_parity_frame_checker;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          resetN;
    logic          serialData, serialValid, frameStart, outputReady, counterClear;
    logic [DW-1:0] outputData;
    logic          outputParityError, outputValid, overrun;
    logic [CW-1:0] errorCount;

    logic       sd7, sv7, fs7, pe7, valid7, overrun7;
    logic [6:0] od7;
    logic [7:0] ec7;

    always #5 clock = ~clock;

    parity_frame_checker #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .resetN(resetN), .serialData(serialData), .serialValid(serialValid),
        .frameStart(frameStart), .outputData(outputData), .outputParityError(outputParityError),
        .outputValid(outputValid), .outputReady(outputReady), .overrun(overrun),
        .errorCount(errorCount), .counterClear(counterClear)
    );

    parity_frame_checker #(.DATA_WIDTH(7), .COUNT_WIDTH(8)) dut7 (
        .clock(clock), .resetN(resetN), .serialData(sd7), .serialValid(sv7),
        .frameStart(fs7), .outputData(od7), .outputParityError(pe7),
        .outputValid(valid7), .outputReady(1'b1), .overrun(overrun7),
        .errorCount(ec7), .counterClear(1'b0)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: bits collected since the last frameStart.
    bit            mBits[$];
    logic          mValid = 1'b0;
    logic [DW-1:0] mData  = '0;
    logic          mErr   = 1'b0;
    logic          mOverrun = 1'b0;
    int            mCount = 0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic pickReady(input int mode, input bit last);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            3:       return last;
            default: return 1'($urandom);
        endcase
    endfunction

    task automatic modelStep(input logic v, input logic s, input logic b, input logic r,
                             input logic c);
        bit            done = 0;
        bit            hs   = mValid && r;
        logic [DW-1:0] w    = '0;
        logic          e    = 1'b0;
        if (v) begin
            if (s) begin
                mBits.delete();
                mBits.push_back(b);
            end else if (mBits.size() > 0) begin
                mBits.push_back(b);
            end
            if (mBits.size() == DW + 1) begin
                done = 1;
                for (int i = 0; i < DW; i++) w[i] = mBits[i];
                e = (int'(mBits[DW]) != (1 + $countones(w) + DW) % 2);
                mBits.delete();
            end
        end
        mOverrun = 1'b0;
        if (done) begin
            if (!mValid || r) begin
                mValid = 1'b1;
                mData  = w;
                mErr   = e;
            end else begin
                mOverrun = 1'b1;
            end
        end else if (hs) begin
            mValid = 1'b0;
        end
        if (c) mCount = 0;
        else if (done && e && mCount < (1 << CW) - 1) mCount++;
    endtask

    task automatic compareAll();
        checkValue("outputValid", 32'(outputValid), 32'(mValid));
        if (mValid) begin
            checkValue("outputData", 32'(outputData), 32'(mData));
            checkValue("outputParityError", 32'(outputParityError), 32'(mErr));
        end
        checkValue("overrun", 32'(overrun), 32'(mOverrun));
        checkValue("errorCount", 32'(errorCount), 32'(mCount));
    endtask

    task automatic cycle(input logic v, input logic s, input logic b, input logic r,
                         input logic c);
        serialValid  = v;
        frameStart   = s;
        serialData   = b;
        outputReady  = r;
        counterClear = c;
        @(posedge clock);
        modelStep(v, s, b, r, c);
        #1;
        compareAll();
    endtask

    // readyMode: 0 low, 1 high, 2 random, 3 high only on the parity cycle.
    task automatic sendFrame(input logic [DW-1:0] d, input logic p, input int readyMode,
                             input int gapPct, input logic clrLast);
        for (int i = 0; i <= DW; i++) begin
            while (int'($urandom_range(99)) < gapPct)
                cycle(1'b0, 1'($urandom), 1'($urandom), pickReady(readyMode, 0), 1'b0);
            cycle(1'b1, i == 0, (i < DW) ? d[i] : p, pickReady(readyMode, i == DW),
                  (i == DW) && clrLast);
        end
    endtask

    task automatic send7(input logic [6:0] d, input logic p, input int expCount);
        logic expErr;
        expErr = (int'(p) != (1 + $countones(d) + 7) % 2);
        for (int i = 0; i <= 7; i++) begin
            sv7 = 1'b1;
            fs7 = (i == 0);
            sd7 = (i < 7) ? d[i] : p;
            @(posedge clock);
            #1;
        end
        sv7 = 1'b0;
        checkValue("w7Valid", 32'(valid7), 32'd1);
        checkValue("w7Data", 32'(od7), 32'(d));
        checkValue("w7ParityError", 32'(pe7), 32'(expErr));
        checkValue("w7Count", 32'(ec7), 32'(expCount));
    endtask

    initial begin
        logic [DW-1:0] d;
        int            cnt7;
        resetN = 1'b0;
        serialValid = 0; frameStart = 0; serialData = 0; outputReady = 0; counterClear = 0;
        sv7 = 0; fs7 = 0; sd7 = 0;
        repeat (3) @(posedge clock);
        #1;
        resetN = 1'b1;
        checkValue("resetValid", 32'(outputValid), 32'd0);
        checkValue("resetData", 32'(outputData), 32'd0);
        checkValue("resetCount", 32'(errorCount), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);  // stray bit without frameStart is ignored

        // 0x5A with correct parity, then with a parity error.
        sendFrame(8'h5A, 1'b1, 1, 0, 1'b0);
        checkValue("okData", 32'(outputData), 32'h5A);
        checkValue("okErr", 32'(outputParityError), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h5A, 1'b0, 1, 0, 1'b0);
        checkValue("badErr", 32'(outputParityError), 32'd1);
        checkValue("badCount", 32'(errorCount), 32'd1);

        // Saturation, then clear against a simultaneous increment.
        for (int n = 0; n < 300; n++) sendFrame(8'h5A, 1'b0, 1, 0, 1'b0);
        checkValue("saturated", 32'(errorCount), 32'd255);
        sendFrame(8'h5A, 1'b0, 1, 0, 1'b1);
        checkValue("clearWins", 32'(errorCount), 32'd0);

        // Overrun with a stalled consumer, then ready raised on the parity cycle.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h11, 1'b1, 0, 0, 1'b0);
        sendFrame(8'h22, 1'b1, 0, 0, 1'b0);
        checkValue("holdData", 32'(outputData), 32'h11);
        checkValue("overrunPulse", 32'(overrun), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h11, 1'b1, 0, 0, 1'b0);
        sendFrame(8'h22, 1'b0, 3, 0, 1'b0);
        checkValue("readyLoad", 32'(outputData), 32'h22);
        checkValue("readyValid", 32'(outputValid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Gaps inside a frame, and an abort at bit 4.
        sendFrame(8'hC3, 1'b1, 1, 40, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, 1'($urandom), 1'b1, 1'b0);
        sendFrame(8'h96, 1'b0, 1, 0, 1'b0);
        checkValue("afterAbort", 32'(outputData), 32'h96);

        // Asynchronous reset mid-frame with the buffer full.
        sendFrame(8'h3C, 1'b0, 0, 0, 1'b0);
        d = 8'hA5;
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, d[i], 1'b0, 1'b0);
        #2 resetN = 1'b0;
        #1;
        checkValue("asyncValid", 32'(outputValid), 32'd0);
        checkValue("asyncData", 32'(outputData), 32'd0);
        checkValue("asyncErr", 32'(outputParityError), 32'd0);
        checkValue("asyncOverrun", 32'(overrun), 32'd0);
        checkValue("asyncCount", 32'(errorCount), 32'd0);
        mBits.delete();
        mValid = 1'b0; mOverrun = 1'b0; mCount = 0;
        @(posedge clock);
        #1 resetN = 1'b1;
        sendFrame(8'hE7, 1'b1, 1, 0, 1'b0);
        checkValue("postReset", 32'(outputData), 32'hE7);

        // Random traffic: gaps, aborts, stray bits, random ready and clears.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(9) == 0) begin
                int k = int'($urandom_range(1, DW));
                for (int i = 0; i < k; i++)
                    cycle(1'b1, i == 0, 1'($urandom), 1'($urandom), 1'b0);
            end
            if ($urandom_range(4) == 0)
                cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            sendFrame(8'($urandom), 1'($urandom), 2, 20, $urandom_range(19) == 0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Odd data width.
        cnt7 = 0;
        send7(7'h07, 1'b1, cnt7);
        cnt7++;
        send7(7'h07, 1'b0, cnt7);
        for (int n = 0; n < 20; n++) begin
            logic [6:0] r7;
            logic       p7;
            r7 = 7'($urandom);
            p7 = 1'($urandom);
            if (int'(p7) != (1 + $countones(r7) + 7) % 2) cnt7++;
            send7(r7, p7, cnt7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
